// File: rtl/req_encoder_8_to_3.sv
// Collects events on 8 request lines into a pending bitmap and emits one 3-bit index per
// accepted valid/ready transfer, with round-robin or fixed-priority arbitration.
module req_encoder_8_to_3 #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic [7:0] overrun,
    input  logic       ovr_clr
);

    logic [7:0] req_q;
    logic [2:0] rr_last;

    logic [7:0] ev;
    logic       slot_free;
    logic       load;
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    logic [7:0] clr_mask;

    assign ev        = EDGE_MODE ? (req & ~req_q) : req;
    assign slot_free = ~out_valid | out_ready;
    assign load      = slot_free & (|pending);
    assign clr_mask  = load ? (8'b1 << sel) : 8'b0;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        sel   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        if (ROUND_ROBIN) begin
            // Search starts just after the last grant and wraps through rr_last itself.
            for (int k = 1; k <= 8; k++) begin
                idx = rr_last + 3'(k);
                if (!found && pending[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pending[i]) begin
                    sel = 3'(i);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= 8'h00;
            pending   <= 8'h00;
            overrun   <= 8'h00;
            out_code  <= 3'd0;
            out_valid <= 1'b0;
            rr_last   <= 3'd7;
        end else begin
            req_q   <= req;
            // A fresh event beats a same-cycle grant, so that bit is re-emitted later.
            pending <= ev | (pending & ~clr_mask);
            overrun <= (ovr_clr ? 8'h00 : overrun) | (ev & pending & ~clr_mask);
            if (load) begin
                out_code  <= sel;
                out_valid <= 1'b1;
                rr_last   <= sel;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_req_encoder_8_to_3.sv
// Directed bench for req_encoder_8_to_3: edge-mode round-robin instance plus two
// level-mode instances (round-robin and fixed priority) sharing the same stimulus.
module tb_req_encoder_8_to_3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b0;
    logic       ovr_clr = 1'b0;

    logic [2:0] e_code, lr_code, lf_code;
    logic       e_valid, lr_valid, lf_valid;
    logic [7:0] e_pend, lr_pend, lf_pend;
    logic [7:0] e_ovr, lr_ovr, lf_ovr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    req_encoder_8_to_3 u_edge (
        .clk(clk), .reset(reset), .req(req), .out_code(e_code), .out_valid(e_valid),
        .out_ready(out_ready), .pending(e_pend), .overrun(e_ovr), .ovr_clr(ovr_clr)
    );

    req_encoder_8_to_3 #(.ROUND_ROBIN(1'b1), .EDGE_MODE(1'b0)) u_lvl_rr (
        .clk(clk), .reset(reset), .req(req), .out_code(lr_code), .out_valid(lr_valid),
        .out_ready(out_ready), .pending(lr_pend), .overrun(lr_ovr), .ovr_clr(ovr_clr)
    );

    req_encoder_8_to_3 #(.ROUND_ROBIN(1'b0), .EDGE_MODE(1'b0)) u_lvl_fp (
        .clk(clk), .reset(reset), .req(req), .out_code(lf_code), .out_valid(lf_valid),
        .out_ready(out_ready), .pending(lf_pend), .overrun(lf_ovr), .ovr_clr(ovr_clr)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // T1: reset state, single pulse on req[3]
        out_ready = 1'b1;
        tick();
        check("rst_valid", 8'(e_valid), 8'h0);
        check("rst_code", 8'(e_code), 8'h0);
        check("rst_pend", e_pend, 8'h00);
        check("rst_ovr", e_ovr, 8'h00);
        reset = 1'b0;
        req = 8'h08;
        tick();
        check("t1_e1_valid", 8'(e_valid), 8'h0);
        check("t1_e1_pend", e_pend, 8'h08);
        req = 8'h00;
        tick();
        check("t1_e2_valid", 8'(e_valid), 8'h1);
        check("t1_e2_code", 8'(e_code), 8'h3);
        check("t1_e2_pend", e_pend, 8'h00);
        tick();
        check("t1_e3_valid", 8'(e_valid), 8'h0);
        check("t1_e3_ovr", e_ovr, 8'h00);

        // T2: two simultaneous requests drained under backpressure
        do_reset();
        out_ready = 1'b0;
        req = 8'h81;
        tick();
        check("t2_pend", e_pend, 8'h81);
        req = 8'h00;
        tick();
        check("t2_first_valid", 8'(e_valid), 8'h1);
        check("t2_first_code", 8'(e_code), 8'h0);
        check("t2_first_pend", e_pend, 8'h80);
        tick();
        check("t2_hold_code", 8'(e_code), 8'h0);
        check("t2_hold_valid", 8'(e_valid), 8'h1);
        out_ready = 1'b1;
        tick();
        check("t2_second_code", 8'(e_code), 8'h7);
        check("t2_second_valid", 8'(e_valid), 8'h1);
        check("t2_second_pend", e_pend, 8'h00);
        tick();
        check("t2_drained", 8'(e_valid), 8'h0);

        // T3: level mode with all requests held high
        do_reset();
        out_ready = 1'b1;
        req = 8'hFF;
        tick();
        check("t3_lr_pend", lr_pend, 8'hFF);
        check("t3_lr_idle", 8'(lr_valid), 8'h0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("t3_rr_code%0d", k), 8'(lr_code), 8'(k % 8));
            check($sformatf("t3_fp_code%0d", k), 8'(lf_code), 8'h0);
        end
        check("t3_rr_valid", 8'(lr_valid), 8'h1);
        check("t3_fp_valid", 8'(lf_valid), 8'h1);
        req = 8'h00;

        // T4: overrun on req[2], then clear
        do_reset();
        out_ready = 1'b0;
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        check("t4_slot_code", 8'(e_code), 8'h2);
        req = 8'h04;
        tick();
        check("t4_slot_only_ovr", e_ovr, 8'h00);
        check("t4_repend", e_pend, 8'h04);
        req = 8'h00;
        tick();
        req = 8'h04;
        tick();
        check("t4_ovr_set", e_ovr, 8'h04);
        check("t4_merged_pend", e_pend, 8'h04);
        req = 8'h00;
        out_ready = 1'b1;
        tick();
        check("t4_emit_code", 8'(e_code), 8'h2);
        check("t4_emit_pend", e_pend, 8'h00);
        tick();
        check("t4_emit_done", 8'(e_valid), 8'h0);
        check("t4_ovr_sticky", e_ovr, 8'h04);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("t4_ovr_clr", e_ovr, 8'h00);

        // T5: new edge on req[5] in the cycle pending[5] is loaded
        do_reset();
        out_ready = 1'b0;
        req = 8'h01;
        tick();
        req = 8'h00;
        tick();
        req = 8'h20;
        tick();
        req = 8'h00;
        tick();
        check("t5_pre_pend", e_pend, 8'h20);
        req = 8'h20;
        out_ready = 1'b1;
        tick();
        check("t5_first_code", 8'(e_code), 8'h5);
        check("t5_first_pend", e_pend, 8'h20);
        check("t5_first_ovr", e_ovr, 8'h00);
        req = 8'h00;
        tick();
        check("t5_second_code", 8'(e_code), 8'h5);
        check("t5_second_valid", 8'(e_valid), 8'h1);
        check("t5_second_pend", e_pend, 8'h00);
        tick();
        check("t5_done", 8'(e_valid), 8'h0);
        check("t5_ovr", e_ovr, 8'h00);

        // T6: asynchronous reset mid-operation, req held across release
        do_reset();
        out_ready = 1'b0;
        req = 8'h01;
        tick();
        req = 8'h00;
        tick();
        req = 8'h30;
        tick();
        check("t6_pre_pend", e_pend, 8'h30);
        check("t6_pre_valid", 8'(e_valid), 8'h1);
        req = 8'h01;
        #1 reset = 1'b1;
        #1;
        check("t6_async_valid", 8'(e_valid), 8'h0);
        check("t6_async_pend", e_pend, 8'h00);
        check("t6_async_code", 8'(e_code), 8'h0);
        check("t6_async_ovr", e_ovr, 8'h00);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t6_rel1_valid", 8'(e_valid), 8'h0);
        check("t6_rel1_pend", e_pend, 8'h01);
        tick();
        check("t6_rel2_valid", 8'(e_valid), 8'h1);
        check("t6_rel2_code", 8'(e_code), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
